// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed display scanner for the clock/date/timer pages.
// Each scan frame is drawn from a snapshot taken at the frame boundary.
module clock_display_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hr,
  input  logic [5:0]  min,
  input  logic [5:0]  sec,
  input  logic        AM_PM,
  input  logic [4:0]  day,
  input  logic [3:0]  month,
  input  logic [11:0] year,
  input  logic [5:0]  timer_min_left,
  input  logic [5:0]  timer_sec_left,
  input  logic        timer_buzzer,
  input  logic        alarm_buzzer,
  input  logic        page_btn,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        led_pm,
  output logic [1:0]  page
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    PG_TIME  = 2'd0,
    PG_DATE  = 2'd1,
    PG_TIMER = 2'd2,
    PG_BAD   = 2'd3
  } page_e;

  typedef struct packed {
    logic [5:0]  hr;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic        pm;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [5:0]  tmin;
    logic [5:0]  tsec;
    logic        tbuz;
    logic        abuz;
    page_e       page;
  } snap_t;

  page_e      page_q, page_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0] d_q, d_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic       blink_q, blink_d;
  snap_t      snap_q, snap_d;
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       led_q, led_d;

  logic       tick, wrap, blank;
  logic [6:0] y100;
  logic [7:0] p0, p1, p2;
  logic [3:0] code;

  function automatic logic [7:0] bcd(input logic [6:0] v);
    logic [3:0] t;
    t = '0;
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(k * 10)) t = 4'(k);
    end
    return {t, 4'(v - 7'(t) * 7'd10)};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      4'd10:   g = 7'h3F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // page steps immediately; the frame picks it up at the next snapshot
  always_comb begin
    page_d = page_q;
    if (page_btn) begin
      unique case (page_q)
        PG_TIME:  page_d = PG_DATE;
        PG_DATE:  page_d = PG_TIMER;
        PG_TIMER: page_d = PG_TIME;
        PG_BAD:   page_d = PG_TIME;
      endcase
    end
  end

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    wrap    = tick && (d_q == 3'd5);
    presc_d = tick ? '0 : presc_q + 1'b1;
    d_d     = d_q;
    if (tick) d_d = (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    snap_d  = snap_q;
    if (wrap) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
      snap_d.hr    = hr;
      snap_d.min   = min;
      snap_d.sec   = sec;
      snap_d.pm    = AM_PM;
      snap_d.day   = day;
      snap_d.month = month;
      snap_d.year  = year;
      snap_d.tmin  = timer_min_left;
      snap_d.tsec  = timer_sec_left;
      snap_d.tbuz  = timer_buzzer;
      snap_d.abuz  = alarm_buzzer;
      snap_d.page  = page_q;
    end
  end

  always_comb begin
    y100 = 7'(snap_q.year % 12'd100);
    p0   = bcd({1'b0, snap_q.hr});
    p1   = bcd({1'b0, snap_q.min});
    p2   = bcd({1'b0, snap_q.sec});
    unique case (snap_q.page)
      PG_DATE: begin
        p0 = bcd({2'b0, snap_q.day});
        p1 = bcd({3'b0, snap_q.month});
        p2 = bcd(y100);
      end
      PG_TIMER: begin
        p0 = 8'hAA;
        p1 = bcd({1'b0, snap_q.tmin});
        p2 = bcd({1'b0, snap_q.tsec});
      end
      PG_TIME, PG_BAD: ;
    endcase
    case (d_q)
      3'd0:    code = p0[7:4];
      3'd1:    code = p0[3:0];
      3'd2:    code = p1[7:4];
      3'd3:    code = p1[3:0];
      3'd4:    code = p2[7:4];
      3'd5:    code = p2[3:0];
      default: code = 4'hF;
    endcase
    blank = (snap_q.tbuz | snap_q.abuz) & blink_q;
    an_d  = ~(6'b000001 << d_q);
    seg_d = glyph(code);
    dp_d  = ~((d_q == 3'd1) || (d_q == 3'd3));
    led_d = (snap_q.page == PG_TIME) & snap_q.pm;
    if (blank) begin
      an_d  = 6'h3F;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page_q  <= PG_TIME;
      presc_q <= '0;
      d_q     <= '0;
      fcnt_q  <= '0;
      blink_q <= 1'b0;
      snap_q  <= '0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      page_q  <= page_d;
      presc_q <= presc_d;
      d_q     <= d_d;
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      led_q   <= led_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign led_pm = led_q;
  assign page   = page_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed bench for clock_display_scanner with a per-slot scoreboard.
// Expected frames are queued before the cycles that display them.
module tb_clock_display_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  hr, min, sec;
  logic        AM_PM;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;
  logic [5:0]  timer_min_left, timer_sec_left;
  logic        timer_buzzer, alarm_buzzer, page_btn;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp, led_pm;
  logic [1:0]  page;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       led;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  clock_display_scanner #(.SCAN_DIV(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset),
    .hr(hr), .min(min), .sec(sec), .AM_PM(AM_PM),
    .day(day), .month(month), .year(year),
    .timer_min_left(timer_min_left),
    .timer_sec_left(timer_sec_left),
    .timer_buzzer(timer_buzzer),
    .alarm_buzzer(alarm_buzzer),
    .page_btn(page_btn),
    .an(an), .seg(seg), .dp(dp),
    .led_pm(led_pm), .page(page)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gl(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_an", 32'(an), 32'h3F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_led", 32'(led_pm), 32'h0);
    chk("rst_page", 32'(page), 32'h0);
  endtask

  // codes: six nibbles, leftmost digit first; A = dash
  task automatic push_frame(input logic [23:0] codes,
                            input logic led, input logic blank);
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      e.an  = blank ? 6'h3F : ~(6'b000001 << k);
      e.seg = blank ? 7'h7F : gl(codes[23-4*k -: 4]);
      e.dp  = blank ? 1'b1 : !(k == 1 || k == 3);
      e.led = led;
      sb.push_back(e);
      sb.push_back(e);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("dp", 32'(dp), 32'(e.dp));
      chk("led_pm", 32'(led_pm), 32'(e.led));
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input logic [1:0] exp_page);
    page_btn = 1'b1;
    cycle();
    page_btn = 1'b0;
    chk("page", 32'(page), 32'(exp_page));
  endtask

  initial begin
    hr = 6'd12; min = 6'd34; sec = 6'd56; AM_PM = 1'b1;
    day = 5'd7; month = 4'd4; year = 12'd2025;
    timer_min_left = 6'd3; timer_sec_left = 6'd9;
    timer_buzzer = 1'b0; alarm_buzzer = 1'b0; page_btn = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk);
    reset = 1'b1;

    push_frame(24'h000000, 1'b0, 1'b0);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b0);
    press(2'd1);
    run(11);
    push_frame(24'h070425, 1'b0, 1'b0);
    press(2'd2);
    run(11);
    push_frame(24'hAA0309, 1'b0, 1'b0);
    press(2'd0);
    sec = 6'd55;
    run(11);
    push_frame(24'h123455, 1'b1, 1'b0);
    run(6);
    sec = 6'd56;
    alarm_buzzer = 1'b1;
    run(6);
    push_frame(24'h123456, 1'b1, 1'b0);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b1);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b1);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b0);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b0);
    run(6);
    alarm_buzzer = 1'b0;
    run(6);
    push_frame(24'h123456, 1'b1, 1'b0);
    run(6);
    timer_buzzer = 1'b1;
    run(6);
    push_frame(24'h123456, 1'b1, 1'b1);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b0);
    press(2'd1);
    run(5);

    #2 reset = 1'b0;
    #1 chk_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 chk_reset();
    @(negedge clk);
    reset = 1'b1;
    push_frame(24'h000000, 1'b0, 1'b0);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b0);
    run(12);
    push_frame(24'h123456, 1'b1, 1'b1);
    run(12);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
